// File: rtl/matmul_pkg.sv
// Shared constants, FSM state type and index helpers for the 3x3 sequential matrix multiplier.
package matmul_pkg;

  localparam int DIM       = 3;
  localparam int N_ELEM    = DIM * DIM;
  localparam int IDX_W     = 4;
  localparam int ACC_GUARD = 2;  // headroom bits for summing DIM products

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic int acc_width(input int data_w);
    return 2 * data_w + ACC_GUARD;
  endfunction

  // A is row-major: element (e/3, k).  B is row-major: element (k, e%3).
  function automatic logic [IDX_W-1:0] a_idx(input logic [IDX_W-1:0] e, input logic [1:0] k);
    return (e / IDX_W'(DIM)) * IDX_W'(DIM) + IDX_W'(k);
  endfunction

  function automatic logic [IDX_W-1:0] b_idx(input logic [IDX_W-1:0] e, input logic [1:0] k);
    return IDX_W'(k) * IDX_W'(DIM) + (e % IDX_W'(DIM));
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Unsigned multiply-accumulate: loads the product on the first term, otherwise adds it.
module matmul_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_W      = 2 * DATA_WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_first,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [ACC_W-1:0]      o_acc
);

  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [ACC_W-1:0]        r_acc;

  assign w_prod = i_a * i_b;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_first ? ACC_W'(w_prod) : r_acc + ACC_W'(w_prod);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for C = A x B (3x3) over synchronous-ROM operands; one MAC, one element at a time.
// Optional busy-cycle counter enabled by defining MATMUL_SEQ_PERF_CNT_EN.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_W      = acc_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [IDX_W-1:0]      o_a_addr,
  output logic [IDX_W-1:0]      o_b_addr,
  input  logic [DATA_WIDTH-1:0] i_a_data,
  input  logic [DATA_WIDTH-1:0] i_b_data,
  output logic                  o_c_we,
  input  logic                  i_c_ready,
  output logic [IDX_W-1:0]      o_c_addr,
  output logic [ACC_W-1:0]      o_c_data,
  output logic [15:0]           o_cycle_count
);

  localparam logic [IDX_W-1:0] LAST_E = IDX_W'(N_ELEM - 1);
  localparam logic [1:0]       LAST_K = 2'(DIM - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_e;
  logic [1:0]       r_k;
  logic             r_busy;
  logic             r_done;
  logic             r_c_we;
  logic [IDX_W-1:0] r_a_addr;
  logic [IDX_W-1:0] r_b_addr;
  logic [IDX_W-1:0] r_c_addr;
  logic             r_mac_en;
  logic             r_mac_first;
  logic [ACC_W-1:0] w_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_e         <= '0;
      r_k         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_c_we      <= 1'b0;
      r_a_addr    <= '0;
      r_b_addr    <= '0;
      r_c_addr    <= '0;
      r_mac_en    <= 1'b0;
      r_mac_first <= 1'b0;
    end else begin
      // ROM data returns one cycle after the issue, so the MAC controls trail ISSUE by one cycle.
      r_mac_en    <= (r_state == S_ISSUE);
      r_mac_first <= (r_state == S_ISSUE) && (r_k == 2'd0);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state  <= S_ISSUE;
            r_busy   <= 1'b1;
            r_e      <= '0;
            r_k      <= '0;
            r_a_addr <= a_idx('0, 2'd0);
            r_b_addr <= b_idx('0, 2'd0);
          end
        end
        S_ISSUE: begin
          if (r_k == LAST_K) begin
            r_state  <= S_DRAIN;
            r_a_addr <= '0;
            r_b_addr <= '0;
          end else begin
            r_k      <= r_k + 2'd1;
            r_a_addr <= a_idx(r_e, r_k + 2'd1);
            r_b_addr <= b_idx(r_e, r_k + 2'd1);
          end
        end
        S_DRAIN: begin
          r_state  <= S_WRITE;
          r_c_we   <= 1'b1;
          r_c_addr <= r_e;
        end
        S_WRITE: begin
          if (i_c_ready) begin
            r_c_we   <= 1'b0;
            r_c_addr <= '0;
            if (r_e == LAST_E) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_ISSUE;
              r_e      <= r_e + 1'b1;
              r_k      <= '0;
              r_a_addr <= a_idx(r_e + 1'b1, 2'd0);
              r_b_addr <= b_idx(r_e + 1'b1, 2'd0);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_e     <= '0;
          r_k     <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  matmul_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_W      (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_en    (r_mac_en),
    .i_first (r_mac_first),
    .i_a     (i_a_data),
    .i_b     (i_b_data),
    .o_acc   (w_acc)
  );

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_a_addr = r_a_addr;
  assign o_b_addr = r_b_addr;
  assign o_c_we   = r_c_we;
  assign o_c_addr = r_c_addr;
  // The accumulator is final on WRITE entry and only moves again after the next ISSUE.
  assign o_c_data = r_c_we ? w_acc : '0;

`ifdef MATMUL_SEQ_PERF_CNT_EN
  logic [15:0] r_cycle_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_count <= '0;
    end else if (r_state == S_IDLE) begin
      if (i_start) r_cycle_count <= '0;
    end else if (r_cycle_count != 16'hFFFF) begin
      r_cycle_count <= r_cycle_count + 16'd1;
    end
  end

  assign o_cycle_count = r_cycle_count;
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: doc/matmul_seq_ctrl.md
MATMUL_SEQ_CTRL -- requirements
Module: matmul_seq_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand element width in bits.
REQ-002 Parameter ACC_W, default 2*DATA_WIDTH+2, result width; holds 3 maximal products without overflow.
REQ-003 clk  in  1  single system clock, all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request to compute C = A x B (3x3), sampled only in IDLE.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 done  out  1  one-cycle pulse after the last C element is written.
REQ-008 a_addr  out  4  A element index, row*3+k.
REQ-009 b_addr  out  4  B element index, k*3+col.
REQ-010 a_data  in  DATA_WIDTH  A operand, valid one cycle after a_addr (synchronous ROM).
REQ-011 b_data  in  DATA_WIDTH  B operand, valid one cycle after b_addr.
REQ-012 c_we  out  1  result valid; held until accepted.
REQ-013 c_ready  in  1  result sink accepts when c_we && c_ready on a rising edge.
REQ-014 c_addr  out  4  C element index, row*3+col, 0..8.
REQ-015 c_data  out  ACC_W  accumulated C element.
REQ-016 cycle_count  out  16  busy-cycle count (see Configuration).

Function
REQ-017 FSM states: IDLE, ISSUE, DRAIN, WRITE, DONE.
REQ-018 IDLE -> ISSUE on start; element index e=0, k=0.
REQ-019 ISSUE: drive a_addr=(e/3)*3+k, b_addr=k*3+(e%3) for k=0,1,2 on 3 consecutive cycles, then -> DRAIN.
REQ-020 Accumulator: one cycle after each issue, acc <= a_data*b_data when k was 0, else acc + a_data*b_data; unsigned arithmetic, full ACC_W width, no truncation.
REQ-021 DRAIN: single cycle absorbing the k=2 product, then -> WRITE.
REQ-022 WRITE: c_we=1, c_addr=e, c_data=acc; c_addr/c_data stable while c_ready=0; on acceptance, e=8 -> DONE, else e+1, k=0, -> ISSUE.
REQ-023 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-024 Latency with c_ready tied high: start sampled at edge 0, element e written at cycle 5+5e, last write cycle 45, done cycle 46, IDLE cycle 47; each c_ready-low cycle adds one cycle.
REQ-025 start while busy (including DONE) is ignored; no queuing.
REQ-026 a_addr, b_addr, c_addr, c_data = 0 whenever not in ISSUE/WRITE respectively.
REQ-027 e and k never exceed 8 and 2; no wrap-around beyond element 8.

Reset
REQ-028 rst, asynchronous, at any time forces IDLE, e=0, k=0, acc=0, busy=0, done=0, c_we=0, all address/data outputs 0, cycle_count=0.
REQ-029 Reset mid-operation discards partial results; next start restarts from element 0.

Configuration
REQ-030 Macro MATMUL_SEQ_PERF_CNT_EN defined: cycle_count clears on start acceptance, increments every busy cycle, saturates at 16'hFFFF, holds after done.
REQ-031 Macro undefined: counter logic absent, cycle_count tied to 0.

Structure
REQ-032 Package matmul_pkg holds DIM=3, N_ELEM=9, IDX_W=4, FSM state enumeration, accumulator-width constant.
REQ-033 One sub-module matmul_mac (multiply, first/accumulate select, acc register); FSM and addressing stay in matmul_seq_ctrl.

Verification
REQ-034 A=1..9, B=9..1 row-major, c_ready=1, start pulse -> writes 30,24,18,84,69,54,138,114,90 to c_addr 0..8 at cycles 5,10..45; done at cycle 46.
REQ-035 All A,B = 255 -> every c_data = 195075 (0x2FA03), no overflow.
REQ-036 c_ready low 4 cycles at element 4 -> c_addr=4, c_data=69 held stable; done at cycle 50.
REQ-037 rst asserted at cycle 20 -> all outputs 0 same cycle; new start -> full correct sequence from element 0.
REQ-038 start re-pulsed at cycles 10 and 46 -> ignored; exactly 9 writes, one done.
REQ-039 With MATMUL_SEQ_PERF_CNT_EN, c_ready=1 -> cycle_count=46 after done; without macro -> cycle_count=0 throughout.
